// File: rtl/uart_data_receiver.sv
// 8N1 UART receiver with an incrementing-byte sequence checker for the board Rx pin.
// Define UART_RX_SEQ_CHECK_EN to build the checker; otherwise seq_err/err_count/locked read 0.
module uart_data_receiver #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        Rx,
  input  logic        ready_clr,
  output logic        ready,
  output logic [7:0]  data_out,
  output logic [7:0]  LEDR,
  output logic        frame_err,
  output logic        seq_err,
  output logic [15:0] err_count,
  output logic        locked
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state, state_next;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             cnt_done;
  logic             sample_data;
  logic             accept;
  logic             frame_bad;

  // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // START waits half a bit to land mid-bit; later phases wait a whole bit.
  assign cnt_done = (state == START) ? (bit_cnt == HALF_LAST) : (bit_cnt == BIT_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    sample_data = 1'b0;
    accept      = 1'b0;
    frame_bad   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt_done) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_done) begin
          sample_data = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_done) begin
          if (rx_s) begin
            accept     = 1'b1;
            state_next = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      data_out  <= 8'h00;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Counter is held at zero outside the timed phases so each phase starts from a clean count.
      if (state == IDLE || state == WAIT_HIGH || cnt_done) bit_cnt <= '0;
      else                                                 bit_cnt <= bit_cnt + 1'b1;

      if (state != DATA)    bit_idx <= 3'd0;
      else if (sample_data) bit_idx <= bit_idx + 3'd1;

      if (sample_data) shift_reg <= {rx_s, shift_reg[7:1]};

      if (accept) data_out <= shift_reg;

      // A new byte outranks a simultaneous clear so no accepted byte goes unflagged.
      if (accept)         ready <= 1'b1;
      else if (ready_clr) ready <= 1'b0;

      frame_err <= frame_bad;
    end
  end

  assign LEDR = data_out;

`ifdef UART_RX_SEQ_CHECK_EN
  logic [7:0] expected;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      locked    <= 1'b0;
      expected  <= 8'h00;
      err_count <= 16'h0000;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (accept) begin
        // Always resynchronise on the received byte so one bad byte costs one error.
        expected <= shift_reg + 8'd1;
        if (!locked) begin
          locked <= 1'b1;
        end else if (shift_reg != expected) begin
          seq_err <= 1'b1;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end
    end
  end
`else
  assign seq_err   = 1'b0;
  assign err_count = 16'h0000;
  assign locked    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_data_receiver.sv
// Directed bench for uart_data_receiver at CLKS_PER_BIT=16; follows UART_RX_SEQ_CHECK_EN if defined.
module tb_uart_data_receiver;

`ifdef UART_RX_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk_50m;
  logic        rst;
  logic        rx;
  logic        ready_clr;
  logic        ready;
  logic [7:0]  data_out;
  logic [7:0]  ledr;
  logic        frame_err;
  logic        seq_err;
  logic [15:0] err_count;
  logic        locked;

  uart_data_receiver #(
    .CLK_FREQ(1600000),
    .BAUD    (100000)
  ) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .Rx       (rx),
    .ready_clr(ready_clr),
    .ready    (ready),
    .data_out (data_out),
    .LEDR     (ledr),
    .frame_err(frame_err),
    .seq_err  (seq_err),
    .err_count(err_count),
    .locked   (locked)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  int n_cmp = 0;
  int n_bad = 0;

  // Cycles seen high on each pulse output; a correct one-cycle pulse adds exactly one.
  int         n_fe = 0;
  int         n_se = 0;
  logic [7:0] last_se_byte = 8'h00;

  always @(negedge clk_50m) begin
    if (frame_err) n_fe++;
    if (seq_err) begin
      n_se++;
      last_se_byte = data_out;
    end
  end

  // Reference sequence-checker state.
  logic        m_locked   = 1'b0;
  logic [7:0]  m_expected = 8'h00;
  logic [15:0] m_err      = 16'h0000;
  int          m_se       = 0;
  int          m_fe       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (SEQ_EN) begin
      if (!m_locked) begin
        m_locked = 1'b1;
      end else if (b != m_expected) begin
        m_se++;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end
      m_expected = b + 8'd1;
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_expected = 8'h00;
    m_err      = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_50m);
  endtask

  // Called on a negedge; drives 16 cycles per bit and optionally pulses ready_clr during the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic clr);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx        = bits[i];
      ready_clr = (i == 0) && clr;
      @(negedge clk_50m);
      ready_clr = 1'b0;
      repeat (15) @(negedge clk_50m);
    end
  endtask

  task automatic send_good(input logic [7:0] b, input logic clr, input string tag);
    send_frame(b, 1'b1, clr);
    model_accept(b);
    check({tag, "_data"}, data_out, b);
    check({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] bits;
    rst       = 1'b1;
    rx        = 1'b1;
    ready_clr = 1'b0;
    repeat (4) @(negedge clk_50m);

    // Reset state
    check("rst_ready", ready, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_ledr", ledr, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_seq_err", seq_err, 1'b0);
    check("rst_err_count", err_count, 16'h0000);
    check("rst_locked", locked, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk_50m);

    // Single byte, sticky ready
    send_good(8'hA5, 1'b0, "a5");
    check("a5_ledr", ledr, 8'hA5);
    check("a5_locked", locked, SEQ_EN);
    check("a5_fe_cnt", n_fe, 0);
    check("a5_se_cnt", n_se, 0);
    repeat (20) @(negedge clk_50m);
    check("a5_ready_held", ready, 1'b1);
    ready_clr = 1'b1;
    @(negedge clk_50m);
    ready_clr = 1'b0;
    check("a5_ready_clr", ready, 1'b0);

    // Wrap through 0xFF -> 0x00, back-to-back
    do_reset();
    send_good(8'hFE, 1'b1, "fe");
    send_good(8'hFF, 1'b1, "ff");
    send_good(8'h00, 1'b1, "w00");
    send_good(8'h01, 1'b1, "w01");
    check("wrap_se_cnt", n_se, m_se);
    check("wrap_err_count", err_count, m_err);
    check("wrap_se_none", n_se, 0);

    // One out-of-sequence byte, then resync
    do_reset();
    send_good(8'h10, 1'b1, "b10");
    send_good(8'h11, 1'b1, "b11");
    send_good(8'h20, 1'b1, "b20");
    check("jump_err_count", err_count, SEQ_EN ? 16'd1 : 16'd0);
    send_good(8'h21, 1'b1, "b21");
    check("resync_se_cnt", n_se, SEQ_EN ? 1 : 0);
    check("resync_err_count", err_count, m_err);
    check("se_byte", last_se_byte, SEQ_EN ? 8'h20 : 8'h00);

    // Framing error: byte discarded, line idles high, next frame accepted
    send_frame(8'h33, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk_50m);
    m_fe++;
    check("fe_cnt", n_fe, m_fe);
    check("fe_ready", ready, 1'b0);
    check("fe_data_kept", data_out, 8'h21);
    check("fe_se_cnt", n_se, m_se);
    send_good(8'h34, 1'b0, "b34");
    check("b34_err_count", err_count, m_err);
    check("b34_se_cnt", n_se, m_se);

    // Short low glitch is rejected
    ready_clr = 1'b1;
    @(negedge clk_50m);
    ready_clr = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk_50m);
    rx = 1'b1;
    repeat (40) @(negedge clk_50m);
    check("glitch_ready", ready, 1'b0);
    check("glitch_data", data_out, 8'h34);
    check("glitch_fe_cnt", n_fe, m_fe);
    check("glitch_se_cnt", n_se, m_se);

    // Reset during data bit 4 aborts the frame
    bits = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat ((i == 4) ? 8 : 16) @(negedge clk_50m);
    end
    rst = 1'b1;
    @(negedge clk_50m);
    check("midrst_ready", ready, 1'b0);
    check("midrst_data", data_out, 8'h00);
    check("midrst_ledr", ledr, 8'h00);
    check("midrst_err_count", err_count, 16'h0000);
    check("midrst_locked", locked, 1'b0);
    rx = 1'b1;
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk_50m);
    check("midrst_fe_cnt", n_fe, m_fe);
    send_good(8'h7E, 1'b0, "b7e");
    check("b7e_locked", locked, SEQ_EN);
    check("b7e_err_count", err_count, m_err);
    check("b7e_se_cnt", n_se, m_se);
    check("b7e_fe_cnt", n_fe, m_fe);

    repeat (5) @(negedge clk_50m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_data_receiver.md
# uart_data_receiver

Receive-side counterpart of the incrementing-byte UART transmitter. Deserialises 8N1 frames arriving on `Rx` and presents each byte with a sticky `ready` flag. Checks that successive bytes form the +1 sequence (0x00..0xFF, wrapping), counts sequence errors, and mirrors the last byte on `LEDR`. Sits directly behind the board `Rx` pin in the 50 MHz domain.

## Interface
- `CLK_FREQ`, 50000000, input clock frequency in Hz
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division, 434 by default)

- `clk_50m`  in  1  system clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `Rx`  in  1  asynchronous serial input; idles high
- `ready_clr`  in  1  clears `ready`
- `ready`  out  1  sticky: a byte is available on `data_out`
- `data_out`  out  8  last accepted byte
- `LEDR`  out  8  copy of `data_out`
- `frame_err`  out  1  one-cycle pulse on a bad stop bit
- `seq_err`  out  1  one-cycle pulse on an out-of-sequence byte
- `err_count`  out  16  saturating count of sequence errors
- `locked`  out  1  the first byte has been received and the checker is armed

## Operation
- `Rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All sampling uses `rx_s`.
- Bit counter `bit_cnt` counts 0..CLKS_PER_BIT-1. `bit_idx` counts 0..7.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on `rx_s`=0, go to START and clear the counter.
  - START: after CLKS_PER_BIT/2 cycles, resample. If 0, go to DATA. If 1, treat it as a glitch and go to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - If 1: accept the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE.
- On accept:
  - `data_out` and `LEDR` take the new byte.
  - `ready` is set to 1. If `ready_clr` is asserted in the same cycle, the set wins.
  - If `ready` was already 1, the old byte is overwritten with no separate flag.
- `ready_clr` clears `ready` on the next edge when no accept occurs in that cycle.
- Sequence checker, on each accept:
  - If `locked`=0: set `locked`=1 and `expected` = byte+1 (8-bit wrap). No error is raised.
  - Otherwise, if byte == `expected`: no error.
  - Otherwise: pulse `seq_err` and increment `err_count`, saturating at 0xFFFF.
  - In every case, `expected` is then set to byte+1 (resynchronises). 0xFF followed by 0x00 is correct.
- Frames rejected by a framing error never reach the checker.

## Timing
- Reset values: `ready`=0, `data_out`=0x00, `LEDR`=0x00, `frame_err`=0, `seq_err`=0, `err_count`=0, `locked`=0. FSM is in IDLE and `expected`=0x00.
- `rst` mid-frame aborts the frame on the next edge with no pulses. A frame already in progress is not recovered. The receiver waits for the next falling edge seen in IDLE.
- Let cycle E be the first edge at which `rx_s`=0 in IDLE. Sample points are E + CLKS_PER_BIT/2 + k·CLKS_PER_BIT:
  - k=0: start bit
  - k=1..8: data bits 0..7
  - k=9: stop bit
- `ready`, `data_out`, `LEDR`, `seq_err`, `err_count` and `locked` all update on the edge that samples the stop bit.
- `frame_err` is valid for exactly the one cycle after that edge. `seq_err` likewise.
- A start bit immediately following a stop bit is accepted. IDLE detects it on the first cycle after the accept.

## Configuration
- `UART_RX_SEQ_CHECK_EN` defined:
  - The sequence checker is built as described above.
- Not defined:
  - The checker logic is omitted.
  - `seq_err`=0, `err_count`=0 and `locked`=0 permanently.
  - Reception, `ready`, `frame_err` and `LEDR` are unchanged.

## Test plan
Run at CLK_FREQ=1600000, BAUD=100000, giving CLKS_PER_BIT=16.

- Send byte 0xA5 → `data_out`=`LEDR`=0xA5, `ready`=1 held until `ready_clr`, `locked`=1, no error pulses.
- Send 0xFE, 0xFF, 0x00, 0x01 back-to-back → four accepts, `seq_err` never pulses, `err_count`=0.
- Send 0x10, 0x11, 0x20, 0x21 → exactly one `seq_err` pulse (on 0x20), `err_count`=1; no further errors after resync.
- Send a frame with stop bit 0 (data 0x33) followed by a line idle high → one `frame_err` pulse, `ready` stays 0, `data_out` unchanged; the next good frame 0x34 is accepted.
- Drive a 4-cycle low glitch on `Rx` → no accept and no pulses; FSM returns to IDLE.
- Assert `rst` during data bit 4 → all outputs return to reset values; the next full frame 0x7E is accepted with `locked` 0→1.
